// File: rtl/alu_chunked_seq_if.sv
// ---------------------------------------------------------------------------
// alu_chunked_seq_if
// Purpose : bundles the operand/result handshake of alu_chunked_seq.
// Signals : in_valid/in_ready  - operand handshake (master -> slave)
//           a, b, cin, op      - operands, carry-in, opcode (00 ADD, 01 SUB,
//                                10 AND, 11 XOR)
//           out_valid/out_ready- result handshake (slave -> master)
//           s, cout            - registered result and carry-out
//           zero, ovf          - result flags, present only when the
//                                ALU_FLAGS_EN macro is defined
// Modports: master - the operand producer / result consumer
//           slave  - the ALU
// ---------------------------------------------------------------------------
interface alu_chunked_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef ALU_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, s, cout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, s, cout, zero, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, s, cout
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, s, cout
  );
`endif
endinterface

// File: rtl/alu_chunked_seq.sv
// ---------------------------------------------------------------------------
// alu_chunked_seq
// Purpose : multi-cycle ALU (ADD, SUB, AND, XOR) that processes WIDTH-bit
//           operands CHUNK bits per clock, holding the inter-chunk carry in a
//           register. One operation in flight; valid/ready on both sides.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous, active-high reset (aborts any operation)
//           bus  - alu_chunked_seq_if.slave (operand/result handshake,
//                  a, b, cin, op, s, cout; zero/ovf when ALU_FLAGS_EN)
// Config  : `define ALU_FLAGS_EN to add registered zero / signed-overflow
//           flags, updated together with s.
// Timing  : accept in cycle t -> out_valid in cycle t+N+1, N = WIDTH/CHUNK.
// ---------------------------------------------------------------------------
module alu_chunked_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_chunked_seq_if.slave   bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
    $error("alu_chunked_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
`ifdef ALU_FLAGS_EN
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               msb_carry;
`endif

  // Per-chunk datapath
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK-1:0]   b_eff;
  logic [CHUNK:0]     sum;
  logic [CHUNK-1:0]   res_chunk;
  logic               carry_next;
  logic               is_arith;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    s_d        = s_q;
    cout_d     = cout_q;
`ifdef ALU_FLAGS_EN
    zero_d     = zero_q;
    ovf_d      = ovf_q;
`endif
    a_chunk    = '0;
    b_chunk    = '0;

    // Select the active chunk with constant part-selects, one per index.
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end

    // SUB is a + ~b + carry; the caller supplies cin=1 for a true subtract.
    is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
    b_eff      = (op_q == OP_SUB) ? ~b_chunk : b_chunk;
    sum        = {1'b0, a_chunk} + {1'b0, b_eff} + (CHUNK+1)'(carry_q);
`ifdef ALU_FLAGS_EN
    // Carry into the chunk MSB, recovered from the sum bit and its inputs.
    msb_carry  = a_chunk[CHUNK-1] ^ b_eff[CHUNK-1] ^ sum[CHUNK-1];
`endif

    if (is_arith) begin
      res_chunk  = sum[CHUNK-1:0];
      carry_next = sum[CHUNK];
    end else begin
      res_chunk  = (op_q == OP_AND) ? (a_chunk & b_chunk) : (a_chunk ^ b_chunk);
      carry_next = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = op_e'(bus.op);
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) begin
            s_d[i*CHUNK +: CHUNK] = res_chunk;
          end
        end
        carry_d = carry_next;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = carry_next;
          state_d = ST_DONE;
`ifdef ALU_FLAGS_EN
          // s_d already holds the final chunk here.
          zero_d  = (s_d == '0);
          ovf_d   = is_arith ? (msb_carry ^ carry_next) : 1'b0;
`endif
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef ALU_FLAGS_EN
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // NOTE: the operand latches are deliberately not reset: they are only read
  // in RUN, which is reachable solely through an accept that loads them.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
`ifdef ALU_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_chunked_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_chunked_seq
// Purpose : directed testbench for alu_chunked_seq. Two instances share clk
//           and rst: dut8 (WIDTH=64, CHUNK=8, N=8) and dut64 (CHUNK=64, N=1).
//           Flag checks are compiled in when ALU_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_chunked_seq;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_chunked_seq_if #(.WIDTH(64)) bus8 ();
  alu_chunked_seq_if #(.WIDTH(64)) bus64 ();

  alu_chunked_seq #(.WIDTH(64), .CHUNK(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  alu_chunked_seq #(.WIDTH(64), .CHUNK(64)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ov(input bit sel);
    return sel ? bus64.out_valid : bus8.out_valid;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b, input logic cin);
    if (sel) begin
      bus64.in_valid = v; bus64.op = op; bus64.a = a; bus64.b = b; bus64.cin = cin;
    end else begin
      bus8.in_valid = v; bus8.op = op; bus8.a = a; bus8.b = b; bus8.cin = cin;
    end
  endtask

  // Present one operation in IDLE, then count cycles until out_valid.
  task automatic run_op(input bit sel, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic cin, output int lat);
    drive(sel, 1'b1, op, a, b, cin);
    tick();
    drive(sel, 1'b0, op, a, b, cin);
    lat = 1;
    while (!ov(sel) && lat < 40) begin
      tick();
      lat++;
    end
    check("out_valid_within_budget", ov(sel), 1'b1);
  endtask

  task automatic finish_op(input bit sel);
    if (sel) bus64.out_ready = 1'b1; else bus8.out_ready = 1'b1;
    tick();
    if (sel) bus64.out_ready = 1'b0; else bus8.out_ready = 1'b0;
    check("after_handshake_out_valid", ov(sel), 1'b0);
    check("after_handshake_in_ready", sel ? bus64.in_ready : bus8.in_ready, 1'b1);
  endtask

  initial begin
    int  lat;
    logic ov_seen;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, OP_ADD, '0, '0, 1'b0);
    drive(1'b1, 1'b0, OP_ADD, '0, '0, 1'b0);
    bus8.out_ready  = 1'b0;
    bus64.out_ready = 1'b0;

    // 1. Reset: two cycles high, then release.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_out_valid", bus8.out_valid, 1'b0);
      check("reset_s", bus8.s, 64'h0);
      check("reset_cout", bus8.cout, 1'b0);
      check("reset_in_ready_low", bus8.in_ready, 1'b0);
    end
    rst = 1'b0;
    tick();
    check("release_in_ready", bus8.in_ready, 1'b1);
    check("release_out_valid", bus8.out_valid, 1'b0);
    check("release_s", bus8.s, 64'h0);

    // 2. ADD all-ones + 1: wraps to zero with carry out, latency N+1 = 9.
    run_op(1'b0, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    check("add_wrap_latency", 64'(lat), 64'd9);
    check("add_wrap_s", bus8.s, 64'h0);
    check("add_wrap_cout", bus8.cout, 1'b1);
    check("done_in_ready_low", bus8.in_ready, 1'b0);
`ifdef ALU_FLAGS_EN
    check("add_wrap_zero", bus8.zero, 1'b1);
    check("add_wrap_ovf", bus8.ovf, 1'b0);
`endif
    finish_op(1'b0);

    // 3. SUB 5 - 7 (borrow), then signed-overflowing ADD.
    run_op(1'b0, OP_SUB, 64'd5, 64'd7, 1'b1, lat);
    check("sub_s", bus8.s, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_cout", bus8.cout, 1'b0);
`ifdef ALU_FLAGS_EN
    check("sub_zero", bus8.zero, 1'b0);
    check("sub_ovf", bus8.ovf, 1'b0);
`endif
    finish_op(1'b0);

    run_op(1'b0, OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    check("add_ovf_s", bus8.s, 64'h8000_0000_0000_0000);
    check("add_ovf_cout", bus8.cout, 1'b0);
`ifdef ALU_FLAGS_EN
    check("add_ovf_ovf", bus8.ovf, 1'b1);
`endif
    finish_op(1'b0);

    // 4. Logic ops ignore cin and force cout=0.
    run_op(1'b0, OP_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, lat);
    check("and_s", bus8.s, 64'hF000_F000_F000_F000);
    check("and_cout", bus8.cout, 1'b0);
`ifdef ALU_FLAGS_EN
    check("and_ovf", bus8.ovf, 1'b0);
`endif
    finish_op(1'b0);

    run_op(1'b0, OP_XOR, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, lat);
    check("xor_s", bus8.s, 64'h0FF0_0FF0_0FF0_0FF0);
    check("xor_cout", bus8.cout, 1'b0);
    finish_op(1'b0);

    // 5. Backpressure: hold DONE for 5 cycles while new operands are offered.
    run_op(1'b0, OP_ADD, 64'd10, 64'd20, 1'b0, lat);
    drive(1'b0, 1'b1, OP_ADD, 64'd100, 64'd200, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", bus8.out_valid, 1'b1);
      check("bp_s_stable", bus8.s, 64'd30);
      check("bp_cout_stable", bus8.cout, 1'b0);
      check("bp_in_ready", bus8.in_ready, 1'b0);
    end
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    check("bp_release_in_ready", bus8.in_ready, 1'b1);
    check("bp_release_out_valid", bus8.out_valid, 1'b0);
    check("bp_old_s_kept", bus8.s, 64'd30);
    tick();
    drive(1'b0, 1'b0, OP_ADD, 64'd100, 64'd200, 1'b0);
    check("bp_new_op_taken", bus8.in_ready, 1'b0);
    lat = 1;
    while (!bus8.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("bp_new_latency", 64'(lat), 64'd9);
    check("bp_new_s", bus8.s, 64'd300);
    finish_op(1'b0);

    // 6. Reset during RUN at idx=3 aborts the operation.
    drive(1'b0, 1'b1, OP_ADD, 64'd1, 64'd1, 1'b0);
    tick();
    drive(1'b0, 1'b0, OP_ADD, 64'd1, 64'd1, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_out_valid", bus8.out_valid, 1'b0);
    check("abort_s_cleared", bus8.s, 64'h0);
    rst = 1'b0;
    ov_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      ov_seen = ov_seen | bus8.out_valid;
    end
    check("abort_no_out_valid", ov_seen, 1'b0);
    check("abort_idle_in_ready", bus8.in_ready, 1'b1);

    // in_valid together with rst: not accepted.
    rst = 1'b1;
    drive(1'b0, 1'b1, OP_ADD, 64'd9, 64'd9, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, OP_ADD, 64'd9, 64'd9, 1'b0);
    tick();
    check("rst_valid_not_taken", bus8.in_ready, 1'b1);
    check("rst_valid_out_valid", bus8.out_valid, 1'b0);

    run_op(1'b0, OP_ADD, 64'd3, 64'd4, 1'b0, lat);
    check("post_abort_latency", 64'(lat), 64'd9);
    check("post_abort_s", bus8.s, 64'd7);
    finish_op(1'b0);

    // N=1 instance: same wrap-around ADD, out_valid at t+2.
    run_op(1'b1, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    check("n1_latency", 64'(lat), 64'd2);
    check("n1_s", bus64.s, 64'h0);
    check("n1_cout", bus64.cout, 1'b1);
`ifdef ALU_FLAGS_EN
    check("n1_zero", bus64.zero, 1'b1);
`endif
    finish_op(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
